// File: rtl/fpga_link_pkg.sv
// Shared types and constants for the FPGA-side chip transmit link.
package fpga_link_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    REQ,
    ACKLO
  } state_e;

  // Flops in the chip_ack synchroniser chain.
  localparam int unsigned SYNC_STAGES = 2;

  // Number of pad-width beats needed to carry one host word.
  function automatic int unsigned beats(input int unsigned data_width,
                                        input int unsigned port_width);
    return data_width / port_width;
  endfunction

endpackage

// File: rtl/fpga_link_fifo.sv
// Synchronous host-word FIFO with first-word fall-through read data.
// Pushes while full and pops while empty are ignored.
module fpga_link_fifo
  import fpga_link_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [DATA_WIDTH-1:0]    wdata_i,
  input  logic                     pop_i,
  output logic [DATA_WIDTH-1:0]    rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic                  do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer and occupancy next-state; pointers wrap naturally (DEPTH is a power of 2).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fpga_chip_tx_link.sv
// FPGA-side transmit link: buffers host words and serialises each into
// PORT_WIDTH beats over a 4-phase req/ack handshake, cfg_burst_len words per burst.
// Optional macro FPGA_LINK_PARITY_EN adds chip_par (XOR of chip_data).
module fpga_chip_tx_link
  import fpga_link_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 128,
  parameter int unsigned PORT_WIDTH  = 32,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned BURST_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_start,
  input  logic [BURST_WIDTH-1:0]        cfg_burst_len,
  output logic                          busy,
  output logic                          done,
  input  logic                          in_valid,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic                          in_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          chip_req,
  output logic [PORT_WIDTH-1:0]         chip_data,
  output logic                          chip_last,
`ifdef FPGA_LINK_PARITY_EN
  output logic                          chip_par,
`endif
  input  logic                          chip_ack
);

  localparam int unsigned    BEATS     = beats(DATA_WIDTH, PORT_WIDTH);
  localparam int unsigned    BCW       = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

  state_e                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   ack_sync_q;
  logic                     ack_s;
  logic [BURST_WIDTH-1:0]   len_q, len_d;
  logic [BURST_WIDTH-1:0]   word_cnt_q, word_cnt_d;
  logic [BCW-1:0]           beat_cnt_q, beat_cnt_d;
  logic [DATA_WIDTH-1:0]    shift_q, shift_d;
  logic                     chip_req_q, chip_req_d;
  logic [PORT_WIDTH-1:0]    chip_data_q, chip_data_d;
  logic                     chip_last_q, chip_last_d;
  logic                     done_q, done_d;
  logic                     last_word;

  logic                     fifo_full, fifo_empty, fifo_pop;
  logic [DATA_WIDTH-1:0]    fifo_rdata;

  fpga_link_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (in_valid && in_ready),
    .wdata_i (in_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign in_ready  = !fifo_full;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign chip_req  = chip_req_q;
  assign chip_data = chip_data_q;
  assign chip_last = chip_last_q;
  assign ack_s     = ack_sync_q[SYNC_STAGES-1];
  assign last_word = (word_cnt_q == len_q - BURST_WIDTH'(1));

  // chip_ack is asynchronous; only the synchronised copy is used.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack_sync_q <= '0;
    else        ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], chip_ack};
  end

  // Next-state, counters and beat data; chip_req/chip_data are registered outputs.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    word_cnt_d  = word_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    shift_d     = shift_q;
    chip_data_d = chip_data_q;
    chip_last_d = chip_last_q;
    chip_req_d  = 1'b0;
    done_d      = 1'b0;
    fifo_pop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_start && cfg_burst_len != '0) begin
          len_d      = cfg_burst_len;
          word_cnt_d = '0;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          shift_d     = fifo_rdata;
          chip_data_d = fifo_rdata[PORT_WIDTH-1:0];
          beat_cnt_d  = '0;
          chip_last_d = (LAST_BEAT == '0) && last_word;
          state_d     = REQ;
        end
      end
      REQ: begin
        if (ack_s) state_d = ACKLO;
        else       chip_req_d = 1'b1;
      end
      ACKLO: begin
        if (!ack_s) begin
          if (beat_cnt_q != LAST_BEAT) begin
            // Shifting the word right keeps the next beat in the low slice.
            beat_cnt_d  = beat_cnt_q + BCW'(1);
            shift_d     = shift_q >> PORT_WIDTH;
            chip_data_d = shift_d[PORT_WIDTH-1:0];
            chip_last_d = (beat_cnt_d == LAST_BEAT) && last_word;
            state_d     = REQ;
          end else if (!last_word) begin
            word_cnt_d = word_cnt_q + BURST_WIDTH'(1);
            state_d    = LOAD;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, counters and output registers; reset drops chip_req immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      word_cnt_q  <= '0;
      beat_cnt_q  <= '0;
      shift_q     <= '0;
      chip_req_q  <= 1'b0;
      chip_data_q <= '0;
      chip_last_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      word_cnt_q  <= word_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      shift_q     <= shift_d;
      chip_req_q  <= chip_req_d;
      chip_data_q <= chip_data_d;
      chip_last_q <= chip_last_d;
      done_q      <= done_d;
    end
  end

`ifdef FPGA_LINK_PARITY_EN
  logic chip_par_q;
  assign chip_par = chip_par_q;

  // Parity is registered alongside chip_data so both change together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chip_par_q <= 1'b0;
    else        chip_par_q <= ^chip_data_d;
  end
`else
  // Without parity, chip_data alone carries the beat.
`endif

endmodule
